// File: rtl/serdes_pkg.sv
// Shared definitions for the UART-side serializer/deserializer pair.
// Holds the default word and byte widths that the splitter and the
// concatenator agree on, plus the splitter's state type.
package serdes_pkg;

    localparam int WORD_W = 32;  // default core-side word width
    localparam int BYTE_W = 8;   // default UART-side chunk width

    typedef enum logic {
        IDLE,  // no word held; ready for a new one
        SEND   // a word is held and its chunks are being emitted
    } split_state_t;

endpackage

// File: rtl/split.sv
// split: word-to-chunk serializer.
// Accepts one DATAW_IN-bit word over a valid/ready handshake and emits it as
// SPLIT_NUM chunks of DATAW_OUT bits over a second valid/ready handshake.
// Least-significant chunk first unless MSB_FIRST is set.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   din holds a word to send
//   in_ready   word is accepted this cycle (may depend on out_ready)
//   din        word to serialize
//   out_valid  dout holds a valid chunk (registered state only)
//   out_ready  consumer takes dout this cycle
//   dout       current chunk
//   last       dout is the final chunk of its word
//   busy       a word is held
module split
    import serdes_pkg::*;
#(
    parameter int DATAW_IN      = WORD_W,
    parameter int DATAW_OUT     = BYTE_W,
    parameter int DATAW_OUT_LEN = $clog2(DATAW_OUT),
    parameter int SPLIT_NUM     = DATAW_IN >> DATAW_OUT_LEN,
    parameter int SPLIT_LEN     = $clog2(SPLIT_NUM),
    parameter bit MSB_FIRST     = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAW_IN-1:0]  din,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAW_OUT-1:0] dout,
    output logic                 last,
    output logic                 busy
);

    localparam logic [SPLIT_LEN-1:0] LAST_IDX = SPLIT_LEN'(SPLIT_NUM - 1);
    localparam int                   LO_W     = SPLIT_LEN + DATAW_OUT_LEN;

    split_state_t         r_state;
    split_state_t         w_next_state;
    logic [SPLIT_LEN-1:0] r_counter;
    logic [DATAW_IN-1:0]  r_word_buf;

    logic                 w_last_chunk;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic [SPLIT_LEN-1:0] w_index;
    logic [LO_W-1:0]      w_slice_lo;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake outputs.
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_last_chunk = (r_counter == LAST_IDX);
        out_valid    = 1'b0;
        busy         = 1'b0;
        last         = 1'b0;
        in_ready     = 1'b0;

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                last      = w_last_chunk;
                // The final chunk leaving frees the buffer in the same cycle,
                // so a waiting word can be loaded with no bubble.
                in_ready  = out_ready && w_last_chunk;
                if (out_ready && w_last_chunk && !in_valid) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase

        w_in_fire  = in_valid && in_ready;
        w_out_fire = out_valid && out_ready;
    end

    // Word buffer and chunk counter. A reload takes priority: it can only
    // coincide with the final chunk firing, where the counter restarts anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_buf <= '0;
            r_counter  <= '0;
        end else if (w_in_fire) begin
            r_word_buf <= din;
            r_counter  <= '0;
        end else if (w_out_fire) begin
            r_counter <= w_last_chunk ? '0 : r_counter + SPLIT_LEN'(1);
        end
    end

    // Chunk selection from registers only; the low bound is the chunk index
    // shifted up by the chunk width exponent.
    always_comb begin
        w_index    = MSB_FIRST ? (LAST_IDX - r_counter) : r_counter;
        w_slice_lo = {w_index, {DATAW_OUT_LEN{1'b0}}};
        dout       = r_word_buf[w_slice_lo +: DATAW_OUT];
    end

endmodule

// File: tb/tb_split.sv
// Self-checking bench for split: directed scenarios on an LSB-first and an
// MSB-first instance, then a randomized round trip whose chunks are
// reassembled by the bench and compared with the words that were sent.
module tb_split;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_last, a_busy;
    logic [31:0] a_din;
    logic [7:0]  a_dout;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_last, b_busy;
    logic [31:0] b_din;
    logic [7:0]  b_dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    split #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .din(a_din),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .dout(a_dout),
        .last(a_last), .busy(a_busy)
    );

    split #(.MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout),
        .last(b_last), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: chunk k of a word in transmission order.
    function automatic logic [7:0] chunk_of(input logic [31:0] w, input int k, input bit msb);
        int idx;
        idx = msb ? 3 - k : k;
        return 8'((w >> (8 * idx)) & 32'hFF);
    endfunction

    // LSB instance already showing chunk 0 of w with out_ready=1: check all
    // four chunks, leaving time just after the edge that consumed the last.
    task automatic expect_word_a(input string tag, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_valid"}, a_out_valid, 1'b1);
            check({tag, "_dout"}, a_dout, chunk_of(w, k, 1'b0));
            check({tag, "_last"}, a_last, k == 3);
            step();
        end
    endtask

    logic [31:0] sent_q[$];
    logic [31:0] acc;
    int          nbytes;
    int          n_sent;
    int          n_recv;
    bit          in_fire, out_fire;

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b0; a_din = '0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_din = '0; b_out_ready = 1'b0;
        #3;
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_in_ready", a_in_ready, 1'b1);
        check("rst_busy", a_busy, 1'b0);
        check("rst_dout", a_dout, 8'h00);
        check("rst_last", a_last, 1'b0);
        #9 rst = 1'b0;
        step();

        // Single word, consumer always ready.
        a_in_valid = 1'b1; a_din = 32'hDEADBEEF; a_out_ready = 1'b1;
        #1;
        check("single_in_ready", a_in_ready, 1'b1);
        step();
        a_in_valid = 1'b0;
        check("single_busy", a_busy, 1'b1);
        expect_word_a("single", 32'hDEADBEEF);
        check("single_idle_valid", a_out_valid, 1'b0);
        check("single_idle_busy", a_busy, 1'b0);
        check("single_idle_in_ready", a_in_ready, 1'b1);

        // Back-to-back words: eight chunks with no gap.
        a_in_valid = 1'b1; a_din = 32'h03020100;
        step();
        a_din = 32'h07060504;
        for (int k = 0; k < 8; k++) begin
            check("b2b_valid", a_out_valid, 1'b1);
            check("b2b_dout", a_dout, 8'(k));
            check("b2b_last", a_last, (k % 4) == 3);
            check("b2b_in_ready", a_in_ready, (k % 4) == 3);
            step();
            if (k == 3) a_in_valid = 1'b0;
        end
        check("b2b_idle", a_out_valid, 1'b0);

        // Backpressure holds BE for three cycles.
        a_in_valid = 1'b1; a_din = 32'hDEADBEEF;
        step();
        a_in_valid = 1'b0;
        check("bp_first", a_dout, 8'hEF);
        step();
        check("bp_second", a_dout, 8'hBE);
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_dout", a_dout, 8'hBE);
            check("bp_hold_last", a_last, 1'b0);
            check("bp_hold_valid", a_out_valid, 1'b1);
            check("bp_hold_in_ready", a_in_ready, 1'b0);
        end
        a_out_ready = 1'b1;
        step();
        check("bp_resume", a_dout, 8'hAD);
        step();
        check("bp_final", a_dout, 8'hDE);
        check("bp_final_last", a_last, 1'b1);
        step();
        check("bp_idle", a_out_valid, 1'b0);

        // Asynchronous reset in the middle of a word.
        a_in_valid = 1'b1; a_din = 32'hDEADBEEF;
        step();
        a_in_valid = 1'b0;
        check("ar_first", a_dout, 8'hEF);
        step();
        check("ar_second", a_dout, 8'hBE);
        #2 rst = 1'b1;
        #1;
        check("ar_valid_drop", a_out_valid, 1'b0);
        check("ar_busy_drop", a_busy, 1'b0);
        check("ar_dout_clear", a_dout, 8'h00);
        check("ar_last_clear", a_last, 1'b0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ar_quiet", a_out_valid, 1'b0);
        end
        a_in_valid = 1'b1; a_din = 32'h11223344;
        step();
        a_in_valid = 1'b0;
        expect_word_a("ar_next", 32'h11223344);
        check("ar_next_idle", a_out_valid, 1'b0);

        // MSB-first instance.
        b_in_valid = 1'b1; b_din = 32'hDEADBEEF; b_out_ready = 1'b1;
        step();
        b_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("msb_valid", b_out_valid, 1'b1);
            check("msb_dout", b_dout, chunk_of(32'hDEADBEEF, k, 1'b1));
            check("msb_last", b_last, k == 3);
            step();
        end
        check("msb_idle", b_out_valid, 1'b0);

        // Randomized round trip: reassemble every four chunks.
        n_sent = 0; n_recv = 0; nbytes = 0; acc = '0;
        for (int cyc = 0; cyc < 5000 && n_recv < 100; cyc++) begin
            if (!a_in_valid && n_sent < 100 && $urandom_range(3) != 0) begin
                a_in_valid = 1'b1;
                a_din      = $urandom;
            end
            a_out_ready = ($urandom_range(3) != 0);
            #1;
            in_fire  = a_in_valid && a_in_ready;
            out_fire = a_out_valid && a_out_ready;
            if (in_fire) begin
                sent_q.push_back(a_din);
                n_sent++;
            end
            if (out_fire) begin
                check("rt_last", a_last, nbytes == 3);
                acc    = acc | (32'(a_dout) << (8 * nbytes));
                nbytes = nbytes + 1;
                if (nbytes == 4) begin
                    if (sent_q.size() == 0) begin
                        check("rt_unexpected_word", acc, 32'hX);
                    end else begin
                        check("rt_word", acc, sent_q.pop_front());
                    end
                    n_recv++;
                    nbytes = 0;
                    acc    = '0;
                end
            end
            step();
            if (in_fire) a_in_valid = 1'b0;
        end
        check("rt_words_received", 64'(n_recv), 64'd100);
        check("rt_queue_empty", 64'(sent_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
